rf_port_arbiter: RTL and testbench
==================================

# rf_port_arbiter

Shares the register-file read ports among the per-pipe schedulers. Every execution pipe's scheduler raises a fire request each cycle, tagged with the number of source operands it needs. The arbiter grants requests in rotating-priority, first-fit order until the read ports run out. Denied schedulers keep their RS entry and retry next cycle. Granted requests receive registered read-port assignments that drive the register-read stage one cycle later.

## Interface
Parameters:
- NUM_REQ, default NUM_FUS (4): number of requesting pipes.
- NUM_RD_PORTS, default 4: number of register-file read ports.
- STARVE_LIMIT, default 3: consecutive denials before a requester is promoted (used only with the starvation guard).

Ports:
- clk  in  1  clock; the single clock for the block.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; cancels this cycle's grants.
- req_valid  in  NUM_REQ  fire request per pipe; this is the scheduler's fire_valid.
- req_nsrc  in  2*NUM_REQ  2 bits per requester giving source operands needed, 0..2. Value 3 is illegal and is treated as 2.
- grant  out  NUM_REQ  combinational same-cycle grant per requester.
- rd_port_valid  out  NUM_RD_PORTS  registered; the port is in use.
- rd_port_owner  out  NUM_RD_PORTS*$clog2(NUM_REQ)  registered; the requester index that owns each port.
- rd_port_slot  out  NUM_RD_PORTS  registered; 0 means src0, 1 means src1.

## Operation
- **Allocation order:** scan requesters circularly starting at rr_ptr. The remaining-port count starts at NUM_RD_PORTS.
- **Grant rule:** grant a valid requester if its nsrc is no greater than the remaining ports, then subtract nsrc. Otherwise skip it without blocking later requesters (first-fit).
- **nsrc=0:** a valid requester with nsrc=0 is always granted, even when no ports remain.
- **Port assignment:** ports are assigned in ascending index, in grant order. Each granted requester takes src0 then src1.
- **rr_ptr update:** if any grant is issued, rr_ptr <= (index of the last requester granted in scan order + 1) mod NUM_REQ. With no grants, rr_ptr holds.
- **Flush:** grant is forced to 0. The next-cycle rd_port_valid is 0, rr_ptr holds, and starvation counters clear.
- **Invariant:** when requests exist and ports are sufficient, a requester is never denied. The sum of granted nsrc never exceeds NUM_RD_PORTS.

## Timing
- grant is combinational from req_valid, req_nsrc, rr_ptr and flush within the same cycle. The scheduler uses it that cycle to decide whether its entry stays.
- rd_port_valid, rd_port_owner and rd_port_slot are registered and appear 1 cycle after the grant.
- Unused ports have valid=0, owner=0, slot=0.
- Reset values: rd_port_valid=0, rd_port_owner=0, rd_port_slot=0, rr_ptr=0, starvation counters=0. grant is 0 while rst is high.
- rst asserted mid-operation discards any pending assignment on the next edge.
- rst and flush asserted together: rst wins.

## Configuration
- **RFARB_STARVE_GUARD_EN defined:**
  - Each requester has a saturating counter, width $clog2(STARVE_LIMIT+1).
  - The counter increments when the requester is valid and not granted. It clears when granted, when req_valid=0, or on flush.
  - Requesters whose counter equals STARVE_LIMIT are scanned first, in circular order from rr_ptr, then the normal scan runs over the rest.
- **Undefined:** counters are absent and scanning is pure rotating first-fit.

## Structure
- Shared backend package holds:
  - the constants NUM_FUS and RS_ENTRIES;
  - the typedefs rd_port_assign_t {valid, owner, slot} and nsrc_t (2 bits).
- Sub-module rf_port_alloc is purely combinational. It takes requests, nsrc, rr_ptr and the starved mask, and returns grants, next-pointer and port assignments.
- The top level holds rr_ptr, the starvation counters, and the output registers.

## Test plan
All scenarios use NUM_REQ=4, NUM_RD_PORTS=4, STARVE_LIMIT=3.
1. Hold rst for 2 cycles, then release with no requests -> all outputs 0 and rr_ptr=0.
2. rr_ptr=0; all valid with nsrc=2,2,2,2 -> grant=0011. Next cycle ports0/1 = req0 src0/src1 and ports2/3 = req1 src0/src1; rr_ptr=2. Repeat -> grant=1100, rr_ptr=0.
3. rr_ptr=0; nsrc=2,1,2,1 -> grant=1011 (req2 skipped). Ports: 0,1 to req0, 2 to req1, 3 to req3. rr_ptr=0.
4. rr_ptr=0; nsrc=2,2,0,2 -> grant=0111 (req2 granted with no port). Only ports 0..3 are valid, owned by req0 and req1.
5. With RFARB_STARVE_GUARD_EN, deny req3 (nsrc=2) for 3 cycles while others take all ports -> the 4th cycle grants req3 first, on ports 0/1, and its counter clears.
6. Assert flush during an all-valid cycle -> grant=0000, next cycle rd_port_valid=0, rr_ptr unchanged. Assert rst mid-stream -> outputs are 0 on the next edge.

Source files
------------

// File: rtl/rf_port_arbiter_pkg.sv
// Shared backend constants and register-read port assignment types.
package rf_port_arbiter_pkg;

   localparam int unsigned NUM_FUS    = 4;
   localparam int unsigned RS_ENTRIES = 16;
   localparam int unsigned OWNER_W    = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

   typedef logic [1:0] nsrc_t;

   typedef struct packed {
      logic               valid;
      logic [OWNER_W-1:0] owner;
      logic               slot;
   } rd_port_assign_t;

endpackage

// File: rtl/rf_port_alloc.sv
// Combinational rotating first-fit read-port allocator; starved requesters are scanned first.
module rf_port_alloc
   import rf_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = NUM_FUS,
   parameter int unsigned NUM_RD_PORTS = 4,
   localparam int unsigned PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]                  req_valid_i,
   input  logic [2*NUM_REQ-1:0]                req_nsrc_i,
   input  logic [PTR_W-1:0]                    rr_ptr_i,
   input  logic [NUM_REQ-1:0]                  starved_i,
   output logic [NUM_REQ-1:0]                  grant_o,
   output logic [PTR_W-1:0]                    next_ptr_o,
   output rd_port_assign_t [NUM_RD_PORTS-1:0]  port_assign_o
);

   // Wide enough to hold the port budget and an nsrc of 2 even with a single port.
   localparam int unsigned CNT_W = $clog2(NUM_RD_PORTS + 3);

   always_comb begin
      logic [CNT_W-1:0] rem;
      logic [CNT_W-1:0] port;
      logic [CNT_W-1:0] eff;
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] last;
      nsrc_t            n;
      logic             sel;
      logic             hit;

      grant_o       = '0;
      port_assign_o = '0;
      next_ptr_o    = rr_ptr_i;
      rem           = CNT_W'(NUM_RD_PORTS);
      port          = '0;
      eff           = '0;
      sum           = '0;
      idx           = '0;
      last          = '0;
      n             = '0;
      sel           = 1'b0;
      hit           = 1'b0;

      // Pass 0 serves starved requesters, pass 1 the rest, both circularly from rr_ptr.
      for (int pass = 0; pass < 2; pass++) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            n   = req_nsrc_i[2*k +: 2];
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
               if (PTR_W'(j) == idx) n = req_nsrc_i[2*j +: 2];
            end
            eff = (n == 2'd3) ? CNT_W'(2) : CNT_W'(n);
            sel = (pass == 0) ? starved_i[idx] : !starved_i[idx];
            if (req_valid_i[idx] && sel && (eff <= rem)) begin
               grant_o[idx] = 1'b1;
               rem          = rem - eff;
               last         = idx;
               hit          = 1'b1;
               for (int s = 0; s < 2; s++) begin
                  if (CNT_W'(s) < eff) begin
                     for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                        if (CNT_W'(p) == port) begin
                           port_assign_o[p].valid = 1'b1;
                           port_assign_o[p].owner = OWNER_W'(idx);
                           port_assign_o[p].slot  = 1'(s);
                        end
                     end
                     port = port + CNT_W'(1);
                  end
               end
            end
         end
      end

      if (hit) next_ptr_o = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
   end

endmodule

// File: rtl/rf_port_arbiter.sv
// Register-file read-port arbiter: same-cycle grants, registered port assignments.
// Optional starvation guard enabled by defining RFARB_STARVE_GUARD_EN.
module rf_port_arbiter
   import rf_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = NUM_FUS,
   parameter int unsigned NUM_RD_PORTS = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [2*NUM_REQ-1:0]                req_nsrc,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [NUM_RD_PORTS-1:0]             rd_port_valid,
   output logic [NUM_RD_PORTS*$clog2(NUM_REQ)-1:0] rd_port_owner,
   output logic [NUM_RD_PORTS-1:0]             rd_port_slot
);

   localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned OWN_OUT_W = $clog2(NUM_REQ);

   if (STARVE_LIMIT == 0) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
   rd_port_assign_t [NUM_RD_PORTS-1:0] ports_q, ports_d;
   rd_port_assign_t [NUM_RD_PORTS-1:0] alloc_ports;
   logic [NUM_REQ-1:0]                 alloc_grant;
   logic [NUM_REQ-1:0]                 starved;
   logic [PTR_W-1:0]                   alloc_next;

   rf_port_alloc #(
      .NUM_REQ      (NUM_REQ),
      .NUM_RD_PORTS (NUM_RD_PORTS)
   ) u_alloc (
      .req_valid_i   (req_valid),
      .req_nsrc_i    (req_nsrc),
      .rr_ptr_i      (rr_ptr_q),
      .starved_i     (starved),
      .grant_o       (alloc_grant),
      .next_ptr_o    (alloc_next),
      .port_assign_o (alloc_ports)
   );

   // Flush cancels this cycle's grants and freezes the pointer.
   always_comb begin
      grant    = (rst || flush) ? '0 : alloc_grant;
      ports_d  = flush ? '0 : alloc_ports;
      rr_ptr_d = flush ? rr_ptr_q : alloc_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         ports_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         ports_q  <= ports_d;
      end
   end

`ifdef RFARB_STARVE_GUARD_EN
   localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

   logic [SCNT_W-1:0] starve_q [NUM_REQ];
   logic [SCNT_W-1:0] starve_d [NUM_REQ];

   // Saturating per-requester denial counters.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         starved[i]  = (starve_q[i] == SCNT_W'(STARVE_LIMIT));
         starve_d[i] = starve_q[i];
         if (flush || !req_valid[i] || alloc_grant[i]) starve_d[i] = '0;
         else if (!starved[i])                         starve_d[i] = starve_q[i] + SCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) starve_q[i] <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign starved = '0;
`endif

   always_comb begin
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
         rd_port_valid[p]                         = ports_q[p].valid;
         rd_port_owner[p*OWN_OUT_W +: OWN_OUT_W] = OWN_OUT_W'(ports_q[p].owner);
         rd_port_slot[p]                          = ports_q[p].slot;
      end
   end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter (4 requesters, 4 read ports, starve limit 3).
module tb_rf_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [3:0] req_valid;
   logic [7:0] req_nsrc;
   logic [3:0] grant;
   logic [3:0] rd_port_valid;
   logic [7:0] rd_port_owner;
   logic [3:0] rd_port_slot;

   typedef struct {
      string      name;
      logic       r;
      logic       f;
      logic [3:0] v;
      logic [7:0] n;
      logic [3:0] eg;
      logic [3:0] ev;
      logic [7:0] eo;
      logic [3:0] es;
   } stim_t;

   typedef struct {
      string      name;
      logic [3:0] v;
      logic [7:0] o;
      logic [3:0] s;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rf_port_arbiter #(
      .NUM_REQ      (4),
      .NUM_RD_PORTS (4),
      .STARVE_LIMIT (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_nsrc      (req_nsrc),
      .grant         (grant),
      .rd_port_valid (rd_port_valid),
      .rd_port_owner (rd_port_owner),
      .rd_port_slot  (rd_port_slot)
   );

   // Drive one cycle of stimulus, queue its registered expectation, settle to mid-cycle.
   task automatic apply(input stim_t s);
      rst       = s.r;
      flush     = s.f;
      req_valid = s.v;
      req_nsrc  = s.n;
      sb.push_back('{name: s.name, v: s.ev, o: s.eo, s: s.es});
      #4;
   endtask

   task automatic test_reset();
      stim_t t[$];
      t.push_back('{"reset_hold0", 1, 0, 4'hf, 8'haa, 4'h0, 4'h0, 8'h00, 4'h0});
      t.push_back('{"reset_hold1", 1, 0, 4'hf, 8'haa, 4'h0, 4'h0, 8'h00, 4'h0});
      t.push_back('{"reset_idle",  0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0});
      foreach (t[i]) begin
         exp_t e;
         apply(t[i]);
         checks++;
         if (grant !== t[i].eg) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", t[i].name, grant, t[i].eg);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rd_port_valid, rd_port_owner, rd_port_slot} !== {e.v, e.o, e.s}) begin
            errors++;
            $display("FAIL %s ports: got v=%b o=%h s=%b want v=%b o=%h s=%b",
                     e.name, rd_port_valid, rd_port_owner, rd_port_slot, e.v, e.o, e.s);
         end
      end
   endtask

   task automatic test_rr_pairs();
      stim_t t[$];
      t.push_back('{"rr_pairs_a", 0, 0, 4'hf, 8'haa, 4'b0011, 4'hf, 8'h50, 4'ha});
      t.push_back('{"rr_pairs_b", 0, 0, 4'hf, 8'haa, 4'b1100, 4'hf, 8'hfa, 4'ha});
      foreach (t[i]) begin
         exp_t e;
         apply(t[i]);
         checks++;
         if (grant !== t[i].eg) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", t[i].name, grant, t[i].eg);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rd_port_valid, rd_port_owner, rd_port_slot} !== {e.v, e.o, e.s}) begin
            errors++;
            $display("FAIL %s ports: got v=%b o=%h s=%b want v=%b o=%h s=%b",
                     e.name, rd_port_valid, rd_port_owner, rd_port_slot, e.v, e.o, e.s);
         end
      end
   endtask

   task automatic test_first_fit();
      stim_t t[$];
      t.push_back('{"first_fit",   0, 0, 4'hf, 8'h66, 4'b1011, 4'hf, 8'hd0, 4'b0010});
      t.push_back('{"zero_nsrc",   0, 0, 4'hf, 8'h8a, 4'b0111, 4'hf, 8'h50, 4'ha});
      t.push_back('{"illegal_ns3", 0, 0, 4'h1, 8'h03, 4'b0001, 4'b0011, 8'h00, 4'b0010});
      foreach (t[i]) begin
         exp_t e;
         apply(t[i]);
         checks++;
         if (grant !== t[i].eg) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", t[i].name, grant, t[i].eg);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rd_port_valid, rd_port_owner, rd_port_slot} !== {e.v, e.o, e.s}) begin
            errors++;
            $display("FAIL %s ports: got v=%b o=%h s=%b want v=%b o=%h s=%b",
                     e.name, rd_port_valid, rd_port_owner, rd_port_slot, e.v, e.o, e.s);
         end
      end
   endtask

   // rr_ptr sits at 1; req1/req2 exhaust the ports, req3 is denied, req0 (nsrc=0) wraps the pointer back.
   task automatic test_starvation();
      stim_t t[$];
      t.push_back('{"starve_c1", 0, 0, 4'hf, 8'ha8, 4'b0111, 4'hf, 8'ha5, 4'ha});
      t.push_back('{"starve_c2", 0, 0, 4'hf, 8'ha8, 4'b0111, 4'hf, 8'ha5, 4'ha});
      t.push_back('{"starve_c3", 0, 0, 4'hf, 8'ha8, 4'b0111, 4'hf, 8'ha5, 4'ha});
`ifdef RFARB_STARVE_GUARD_EN
      t.push_back('{"starve_c4", 0, 0, 4'hf, 8'ha8, 4'b1011, 4'hf, 8'h5f, 4'ha});
`else
      t.push_back('{"starve_c4", 0, 0, 4'hf, 8'ha8, 4'b0111, 4'hf, 8'ha5, 4'ha});
`endif
      t.push_back('{"starve_c5", 0, 0, 4'hf, 8'ha8, 4'b0111, 4'hf, 8'ha5, 4'ha});
      foreach (t[i]) begin
         exp_t e;
         apply(t[i]);
         checks++;
         if (grant !== t[i].eg) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", t[i].name, grant, t[i].eg);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rd_port_valid, rd_port_owner, rd_port_slot} !== {e.v, e.o, e.s}) begin
            errors++;
            $display("FAIL %s ports: got v=%b o=%h s=%b want v=%b o=%h s=%b",
                     e.name, rd_port_valid, rd_port_owner, rd_port_slot, e.v, e.o, e.s);
         end
      end
   endtask

   task automatic test_flush_reset();
      stim_t t[$];
      t.push_back('{"flush_cycle",   0, 1, 4'hf, 8'haa, 4'b0000, 4'h0, 8'h00, 4'h0});
      t.push_back('{"after_flush",   0, 0, 4'hf, 8'haa, 4'b0110, 4'hf, 8'ha5, 4'ha});
      t.push_back('{"mid_reset",     1, 0, 4'hf, 8'haa, 4'b0000, 4'h0, 8'h00, 4'h0});
      t.push_back('{"reset_flush",   1, 1, 4'hf, 8'haa, 4'b0000, 4'h0, 8'h00, 4'h0});
      t.push_back('{"after_reset",   0, 0, 4'hf, 8'haa, 4'b0011, 4'hf, 8'h50, 4'ha});
      foreach (t[i]) begin
         exp_t e;
         apply(t[i]);
         checks++;
         if (grant !== t[i].eg) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", t[i].name, grant, t[i].eg);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rd_port_valid, rd_port_owner, rd_port_slot} !== {e.v, e.o, e.s}) begin
            errors++;
            $display("FAIL %s ports: got v=%b o=%h s=%b want v=%b o=%h s=%b",
                     e.name, rd_port_valid, rd_port_owner, rd_port_slot, e.v, e.o, e.s);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      req_nsrc  = '0;
      @(posedge clk); #1;
      test_reset();
      test_rr_pairs();
      test_first_fit();
      test_starvation();
      test_flush_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
